// File: rtl/m1t_lsu_pkg.sv
// Shared types and constants for the M1T core-side load/store port.
package m1t_lsu_pkg;

  localparam int unsigned DATA_W = 16;
  localparam int unsigned RD_W   = 4;

  // Pipeline request opcodes; encoding 3 is reserved and behaves as a fence.
  typedef enum logic [1:0] {
    OP_LOAD  = 2'd0,
    OP_STORE = 2'd1,
    OP_FENCE = 2'd2
  } lsu_op_e;

  // Bus transfer direction.
  localparam logic [1:0] MODE_READ  = 2'b00;
  localparam logic [1:0] MODE_WRITE = 2'b01;

  // Bus data-type field.
  localparam logic [1:0] DT_SBYTE = 2'b00;
  localparam logic [1:0] DT_HALF  = 2'b01;
  localparam logic [1:0] DT_UBYTE = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE        = 2'd0,
    ST_ISSUE       = 2'd1,
    ST_FENCE_DRAIN = 2'd2
  } state_e;

  // Bus beat payload held on the bus while a beat is pending.
  typedef struct packed {
    logic [1:0]        mask;
    logic [1:0]        dtype;
    logic [DATA_W-1:0] data;
    logic [1:0]        mode;
    logic [RD_W-1:0]   wb_dest;
  } beat_t;

  // Saturating 16-bit increment for event counters.
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/m1t_lsu_lane_fmt.sv
// Combinational mapper from byte address / size / store data to bus lanes.
module m1t_lsu_lane_fmt
  import m1t_lsu_pkg::*;
(
  input  logic              is_store,
  input  logic              addr_lsb,
  input  logic              size,
  input  logic              is_unsigned,
  input  logic [DATA_W-1:0] wdata,
  output logic [1:0]        mask_c,
  output logic [DATA_W-1:0] data_c,
  output logic [1:0]        dtype_c
);

  // Loads use both lanes; byte stores pick the lane and replicate the byte.
  always_comb begin
    mask_c  = 2'b11;
    data_c  = '0;
    dtype_c = size ? DT_HALF : (is_unsigned ? DT_UBYTE : DT_SBYTE);
    if (is_store) begin
      if (size) begin
        data_c = wdata;
      end else begin
        mask_c = addr_lsb ? 2'b10 : 2'b01;
        data_c = {wdata[7:0], wdata[7:0]};
      end
    end
  end

endmodule

// File: rtl/m1t_lsu_port.sv
// Core-side initiator for the M1T memory/GPIO bus.
// Optional performance counters are enabled by defining M1T_LSU_PERF_CNT_EN.
module m1t_lsu_port
  import m1t_lsu_pkg::*;
#(
  parameter int unsigned MAX_OUTSTANDING = 2,
  parameter int unsigned ADDR_W          = 16
) (
  input  logic              clk,
  input  logic              async_rst,
  input  logic              clk_en,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [1:0]        req_op,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic              req_size,
  input  logic              req_unsigned,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic [RD_W-1:0]   req_rd,
  output logic [ADDR_W-2:0] core_mem_address_out,
  output logic [1:0]        core_mem_mask_out,
  output logic [1:0]        core_mem_read_fnc_type,
  output logic [DATA_W-1:0] core_mem_data_out,
  output logic [1:0]        core_mem_mode,
  output logic              core_mem_enable,
  output logic              core_mem_input_ready,
  output logic [RD_W-1:0]   core_mem_wb_dest,
  input  logic [DATA_W-1:0] core_mem_data_in,
  input  logic [RD_W-1:0]   core_mem_wb_dest_in,
  input  logic              core_mem_read_ack,
  input  logic              core_mem_available,
  input  logic              core_mem_idle,
  output logic              wb_valid,
  output logic [RD_W-1:0]   wb_rd,
  output logic [DATA_W-1:0] wb_data,
  output logic              misalign_err,
  output logic              lsu_busy
`ifdef M1T_LSU_PERF_CNT_EN
  ,
  output logic [15:0]       perf_loads,
  output logic [15:0]       perf_stores,
  output logic [15:0]       perf_stall_cycles
`endif
);

  localparam int unsigned CNT_W = 3;

  state_e            state_q, state_n;
  logic [CNT_W-1:0]  cnt_q, cnt_n;
  beat_t             beat_q, beat_n;
  logic [ADDR_W-2:0] addr_q, addr_n;
  logic              en_q, en_n;
  logic              mis_q, mis_n;
  logic              wbv_q, wbv_n;
  logic [RD_W-1:0]   wbrd_q, wbrd_n;
  logic [DATA_W-1:0] wbd_q, wbd_n;
  logic              busy_q, busy_n;

  logic              is_load_c, is_store_c, fire_c, take_c, inc_c, dec_c, full_c;
  logic [1:0]        fmt_mask_c, fmt_dtype_c;
  logic [DATA_W-1:0] fmt_data_c;

  assign is_load_c  = (req_op == 2'(OP_LOAD));
  assign is_store_c = (req_op == 2'(OP_STORE));
  assign full_c     = (cnt_q == CNT_W'(MAX_OUTSTANDING));
  assign req_ready  = !async_rst && (state_q == ST_IDLE) && !(is_load_c && full_c);
  assign fire_c     = req_valid && req_ready;
  assign take_c     = (state_q == ST_ISSUE) && core_mem_available;
  assign inc_c      = take_c && (beat_q.mode == MODE_READ);
  assign dec_c      = core_mem_read_ack && (cnt_q != '0);

  m1t_lsu_lane_fmt u_fmt (
    .is_store    (is_store_c),
    .addr_lsb    (req_addr[0]),
    .size        (req_size),
    .is_unsigned (req_unsigned),
    .wdata       (req_wdata),
    .mask_c      (fmt_mask_c),
    .data_c      (fmt_data_c),
    .dtype_c     (fmt_dtype_c)
  );

  // Next-state, outstanding count and registered output values.
  always_comb begin
    state_n = state_q;
    cnt_n   = cnt_q;
    beat_n  = beat_q;
    addr_n  = addr_q;
    en_n    = en_q;
    mis_n   = 1'b0;
    wbv_n   = dec_c;
    wbrd_n  = wbrd_q;
    wbd_n   = wbd_q;

    unique case (state_q)
      ST_IDLE: begin
        if (fire_c) begin
          if (is_load_c || is_store_c) begin
            if (req_size && req_addr[0]) begin
              mis_n = 1'b1;
            end else begin
              addr_n         = req_addr[ADDR_W-1:1];
              beat_n.mask    = fmt_mask_c;
              beat_n.dtype   = fmt_dtype_c;
              beat_n.data    = fmt_data_c;
              beat_n.mode    = is_store_c ? MODE_WRITE : MODE_READ;
              beat_n.wb_dest = is_store_c ? '0 : req_rd;
              en_n           = 1'b1;
              state_n        = ST_ISSUE;
            end
          end else begin
            state_n = ST_FENCE_DRAIN;
          end
        end
      end
      ST_ISSUE: begin
        if (core_mem_available) begin
          en_n    = 1'b0;
          state_n = ST_IDLE;
        end
      end
      ST_FENCE_DRAIN: begin
        if ((cnt_q == '0) && core_mem_idle) begin
          state_n = ST_IDLE;
        end
      end
      default: state_n = ST_IDLE;
    endcase

    if (inc_c && !dec_c) begin
      cnt_n = cnt_q + CNT_W'(1);
    end else if (dec_c && !inc_c) begin
      cnt_n = cnt_q - CNT_W'(1);
    end

    if (dec_c) begin
      wbrd_n = core_mem_wb_dest_in;
      wbd_n  = core_mem_data_in;
    end

    busy_n = (cnt_n != '0) || (state_n != ST_IDLE);
  end

  // State register; everything freezes while clk_en is low.
  always_ff @(posedge clk or posedge async_rst) begin
    if (async_rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      beat_q  <= '0;
      addr_q  <= '0;
      en_q    <= 1'b0;
      mis_q   <= 1'b0;
      wbv_q   <= 1'b0;
      wbrd_q  <= '0;
      wbd_q   <= '0;
      busy_q  <= 1'b0;
    end else if (clk_en) begin
      state_q <= state_n;
      cnt_q   <= cnt_n;
      beat_q  <= beat_n;
      addr_q  <= addr_n;
      en_q    <= en_n;
      mis_q   <= mis_n;
      wbv_q   <= wbv_n;
      wbrd_q  <= wbrd_n;
      wbd_q   <= wbd_n;
      busy_q  <= busy_n;
    end
  end

  assign core_mem_address_out   = addr_q;
  assign core_mem_mask_out      = beat_q.mask;
  assign core_mem_read_fnc_type = beat_q.dtype;
  assign core_mem_data_out      = beat_q.data;
  assign core_mem_mode          = beat_q.mode;
  assign core_mem_wb_dest       = beat_q.wb_dest;
  assign core_mem_enable        = en_q;
  assign core_mem_input_ready   = en_q;
  assign wb_valid               = wbv_q;
  assign wb_rd                  = wbrd_q;
  assign wb_data                = wbd_q;
  assign misalign_err           = mis_q;
  assign lsu_busy               = busy_q;

`ifdef M1T_LSU_PERF_CNT_EN
  logic [15:0] perf_ld_q, perf_st_q, perf_stall_q;

  // Saturating beat and stall event counters.
  always_ff @(posedge clk or posedge async_rst) begin
    if (async_rst) begin
      perf_ld_q    <= '0;
      perf_st_q    <= '0;
      perf_stall_q <= '0;
    end else if (clk_en) begin
      if (inc_c) perf_ld_q <= sat_inc16(perf_ld_q);
      if (take_c && (beat_q.mode == MODE_WRITE)) perf_st_q <= sat_inc16(perf_st_q);
      if (req_valid && !req_ready) perf_stall_q <= sat_inc16(perf_stall_q);
    end
  end

  assign perf_loads        = perf_ld_q;
  assign perf_stores       = perf_st_q;
  assign perf_stall_cycles = perf_stall_q;
`endif

endmodule

// File: tb/tb_m1t_lsu_port.sv
// Scoreboard bench for m1t_lsu_port: directed requests push expected bus beats
// and writebacks; negedge monitors pop and compare.
module tb_m1t_lsu_port;
  import m1t_lsu_pkg::*;

  logic        clk = 1'b0;
  logic        async_rst, clk_en, req_valid, req_ready;
  logic [1:0]  req_op;
  logic [15:0] req_addr, req_wdata;
  logic        req_size, req_unsigned;
  logic [3:0]  req_rd;
  logic [14:0] core_mem_address_out;
  logic [1:0]  core_mem_mask_out, core_mem_read_fnc_type, core_mem_mode;
  logic [15:0] core_mem_data_out, core_mem_data_in, wb_data;
  logic        core_mem_enable, core_mem_input_ready;
  logic [3:0]  core_mem_wb_dest, core_mem_wb_dest_in, wb_rd;
  logic        core_mem_read_ack, core_mem_available, core_mem_idle;
  logic        wb_valid, misalign_err, lsu_busy;
`ifdef M1T_LSU_PERF_CNT_EN
  logic [15:0] perf_loads, perf_stores, perf_stall_cycles;
`endif

  m1t_lsu_port #(.MAX_OUTSTANDING(2), .ADDR_W(16)) dut (
    .clk(clk), .async_rst(async_rst), .clk_en(clk_en),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_addr(req_addr), .req_size(req_size), .req_unsigned(req_unsigned),
    .req_wdata(req_wdata), .req_rd(req_rd),
    .core_mem_address_out(core_mem_address_out), .core_mem_mask_out(core_mem_mask_out),
    .core_mem_read_fnc_type(core_mem_read_fnc_type), .core_mem_data_out(core_mem_data_out),
    .core_mem_mode(core_mem_mode), .core_mem_enable(core_mem_enable),
    .core_mem_input_ready(core_mem_input_ready), .core_mem_wb_dest(core_mem_wb_dest),
    .core_mem_data_in(core_mem_data_in), .core_mem_wb_dest_in(core_mem_wb_dest_in),
    .core_mem_read_ack(core_mem_read_ack), .core_mem_available(core_mem_available),
    .core_mem_idle(core_mem_idle), .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
    .misalign_err(misalign_err), .lsu_busy(lsu_busy)
`ifdef M1T_LSU_PERF_CNT_EN
    , .perf_loads(perf_loads), .perf_stores(perf_stores), .perf_stall_cycles(perf_stall_cycles)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [14:0] addr;
    logic [1:0]  mask;
    logic [1:0]  mode;
    logic [1:0]  dtype;
    logic [15:0] data;
    logic [3:0]  dest;
  } exp_beat_t;

  typedef struct {
    logic [3:0]  rd;
    logic [15:0] data;
  } exp_wb_t;

  exp_beat_t beat_q[$];
  exp_wb_t   wb_q[$];
  int total = 0;
  int bad   = 0;
  int mis_cnt = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Advance to just after the next active edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic exp_beat(input logic [14:0] a, input logic [1:0] m, input logic [1:0] mo,
                          input logic [1:0] dt, input logic [15:0] d, input logic [3:0] ds);
    exp_beat_t e;
    e.addr = a; e.mask = m; e.mode = mo; e.dtype = dt; e.data = d; e.dest = ds;
    beat_q.push_back(e);
  endtask

  task automatic send(input logic [1:0] op, input logic [15:0] a, input logic sz,
                      input logic un, input logic [15:0] wd, input logic [3:0] rd);
    int n = 0;
    req_valid = 1'b1; req_op = op; req_addr = a; req_size = sz;
    req_unsigned = un; req_wdata = wd; req_rd = rd;
    #1;
    while (!req_ready && n < 50) begin
      tick();
      #1;
      n++;
    end
    if (!req_ready) chk("req_accept_timeout", 32'(req_ready), 32'd1);
    tick();
    req_valid = 1'b0;
  endtask

  task automatic ack(input logic [15:0] d, input logic [3:0] rd, input bit expect_wb);
    exp_wb_t w;
    core_mem_read_ack = 1'b1; core_mem_data_in = d; core_mem_wb_dest_in = rd;
    if (expect_wb) begin
      w.rd = rd; w.data = d;
      wb_q.push_back(w);
    end
    tick();
    core_mem_read_ack = 1'b0;
  endtask

  // Beat monitor: a beat is taken on an enabled edge with enable && available.
  always @(negedge clk) begin : mon_beat
    exp_beat_t e;
    if (!async_rst && clk_en && core_mem_enable && core_mem_available) begin
      if (beat_q.size() == 0) begin
        total++; bad++;
        $display("FAIL unexpected_beat: addr %0h with no expected beat", core_mem_address_out);
      end else begin
        e = beat_q.pop_front();
        chk("beat_addr", 32'(core_mem_address_out), 32'(e.addr));
        chk("beat_mask", 32'(core_mem_mask_out), 32'(e.mask));
        chk("beat_mode", 32'(core_mem_mode), 32'(e.mode));
        chk("beat_dest", 32'(core_mem_wb_dest), 32'(e.dest));
        chk("beat_in_rdy", 32'(core_mem_input_ready), 32'd1);
        if (e.mode == MODE_WRITE) chk("beat_data", 32'(core_mem_data_out), 32'(e.data));
        else chk("beat_dtype", 32'(core_mem_read_fnc_type), 32'(e.dtype));
      end
    end
  end

  // Writeback and misalign monitor.
  always @(negedge clk) begin : mon_wb
    exp_wb_t w;
    if (!async_rst && wb_valid) begin
      if (wb_q.size() == 0) begin
        total++; bad++;
        $display("FAIL unexpected_wb: rd %0d data %0h with none expected", wb_rd, wb_data);
      end else begin
        w = wb_q.pop_front();
        chk("wb_rd", 32'(wb_rd), 32'(w.rd));
        chk("wb_data", 32'(wb_data), 32'(w.data));
      end
    end
    if (!async_rst && misalign_err) mis_cnt++;
  end

  initial begin
    async_rst = 1'b1; clk_en = 1'b1; req_valid = 1'b0; req_op = 2'd1;
    req_addr = '0; req_size = 1'b0; req_unsigned = 1'b0; req_wdata = '0; req_rd = '0;
    core_mem_data_in = '0; core_mem_wb_dest_in = '0; core_mem_read_ack = 1'b0;
    core_mem_available = 1'b1; core_mem_idle = 1'b1;
    #2;
    chk("rst_enable", 32'(core_mem_enable), 32'd0);
    chk("rst_wb_valid", 32'(wb_valid), 32'd0);
    chk("rst_misalign", 32'(misalign_err), 32'd0);
    chk("rst_busy", 32'(lsu_busy), 32'd0);
    chk("rst_ready", 32'(req_ready), 32'd0);
    repeat (3) @(posedge clk);
    #1 async_rst = 1'b0;
    #1 chk("post_rst_ready", 32'(req_ready), 32'd1);

    // Byte stores (odd and even lane) and a halfword store.
    exp_beat(15'h0009, 2'b10, MODE_WRITE, DT_SBYTE, 16'hA5A5, 4'd0);
    send(2'd1, 16'h0013, 1'b0, 1'b0, 16'h00A5, 4'd9);
    exp_beat(15'h0020, 2'b01, MODE_WRITE, DT_SBYTE, 16'h3C3C, 4'd0);
    send(2'd1, 16'h0040, 1'b0, 1'b0, 16'h123C, 4'd0);
    exp_beat(15'h0029, 2'b11, MODE_WRITE, DT_HALF, 16'hBEEF, 4'd0);
    send(2'd1, 16'h0052, 1'b1, 1'b0, 16'hBEEF, 4'd0);
    tick(); tick();
    chk("store_busy", 32'(lsu_busy), 32'd0);

    // Halfword load, ack three cycles later, writeback one cycle after ack.
    exp_beat(15'h0010, 2'b11, MODE_READ, DT_HALF, 16'h0000, 4'd5);
    send(2'd0, 16'h0020, 1'b1, 1'b0, 16'h0000, 4'd5);
    tick(); tick();
    chk("load_busy", 32'(lsu_busy), 32'd1);
    ack(16'h1234, 4'd5, 1'b1);
    chk("wb_latency", 32'(wb_valid), 32'd1);
    chk("load_done_busy", 32'(lsu_busy), 32'd0);

    // Ack with nothing outstanding is ignored.
    ack(16'hDEAD, 4'd6, 1'b0);
    chk("stray_ack_busy", 32'(lsu_busy), 32'd0);

    // Signed and unsigned byte loads.
    exp_beat(15'h0040, 2'b11, MODE_READ, DT_SBYTE, 16'h0000, 4'd3);
    send(2'd0, 16'h0081, 1'b0, 1'b0, 16'h0000, 4'd3);
    exp_beat(15'h0041, 2'b11, MODE_READ, DT_UBYTE, 16'h0000, 4'd4);
    send(2'd0, 16'h0082, 1'b0, 1'b1, 16'h0000, 4'd4);
    tick();
    ack(16'hFF80, 4'd3, 1'b1);
    ack(16'h0080, 4'd4, 1'b1);
    tick();

    // Three back-to-back loads against a limit of two.
    exp_beat(15'h0018, 2'b11, MODE_READ, DT_HALF, 16'h0000, 4'd1);
    send(2'd0, 16'h0030, 1'b1, 1'b0, 16'h0000, 4'd1);
    exp_beat(15'h0019, 2'b11, MODE_READ, DT_HALF, 16'h0000, 4'd2);
    send(2'd0, 16'h0032, 1'b1, 1'b0, 16'h0000, 4'd2);
    tick();
    req_valid = 1'b1; req_op = 2'd0; req_addr = 16'h0034; req_size = 1'b1; req_rd = 4'd7;
    #1 chk("full_ready_0", 32'(req_ready), 32'd0);
    tick();
    chk("full_ready_1", 32'(req_ready), 32'd0);
    ack(16'h1111, 4'd1, 1'b1);
    #1 chk("ready_after_ack", 32'(req_ready), 32'd1);
    exp_beat(15'h001A, 2'b11, MODE_READ, DT_HALF, 16'h0000, 4'd7);
    send(2'd0, 16'h0034, 1'b1, 1'b0, 16'h0000, 4'd7);
    ack(16'h2222, 4'd2, 1'b1);
    ack(16'h3333, 4'd7, 1'b1);
    tick();
    chk("three_loads_busy", 32'(lsu_busy), 32'd0);

    // Misaligned halfword load and store are dropped.
    send(2'd0, 16'h0011, 1'b1, 1'b0, 16'h0000, 4'd2);
    chk("misalign_pulse", 32'(misalign_err), 32'd1);
    chk("misalign_no_beat", 32'(core_mem_enable), 32'd0);
    tick();
    chk("misalign_clear", 32'(misalign_err), 32'd0);
    send(2'd1, 16'h0035, 1'b1, 1'b0, 16'h4444, 4'd0);
    chk("misalign_st_no_beat", 32'(core_mem_enable), 32'd0);
    tick();

    // Fence drains two outstanding reads and waits for bus idle.
    exp_beat(15'h0038, 2'b11, MODE_READ, DT_HALF, 16'h0000, 4'd7);
    send(2'd0, 16'h0070, 1'b1, 1'b0, 16'h0000, 4'd7);
    exp_beat(15'h0039, 2'b11, MODE_READ, DT_HALF, 16'h0000, 4'd8);
    send(2'd0, 16'h0072, 1'b1, 1'b0, 16'h0000, 4'd8);
    tick();
    core_mem_idle = 1'b0;
    send(2'd2, 16'h0000, 1'b0, 1'b0, 16'h0000, 4'd0);
    chk("fence_ready", 32'(req_ready), 32'd0);
    chk("fence_busy", 32'(lsu_busy), 32'd1);
    ack(16'hAAAA, 4'd7, 1'b1);
    chk("fence_ack1_ready", 32'(req_ready), 32'd0);
    ack(16'h5555, 4'd8, 1'b1);
    chk("fence_ack2_ready", 32'(req_ready), 32'd0);
    tick();
    chk("fence_not_idle", 32'(req_ready), 32'd0);
    core_mem_idle = 1'b1;
    tick();
    chk("fence_exit_ready", 32'(req_ready), 32'd1);
    chk("fence_exit_busy", 32'(lsu_busy), 32'd0);

    // Reserved opcode behaves as a fence.
    send(2'd3, 16'h0000, 1'b0, 1'b0, 16'h0000, 4'd0);
    chk("rsvd_busy", 32'(lsu_busy), 32'd1);
    tick();
    chk("rsvd_exit_busy", 32'(lsu_busy), 32'd0);

    // Clock enable low freezes a pending beat.
    core_mem_available = 1'b0;
    exp_beat(15'h0050, 2'b01, MODE_WRITE, DT_SBYTE, 16'h6666, 4'd0);
    send(2'd1, 16'h00A0, 1'b0, 1'b0, 16'h0066, 4'd0);
    clk_en = 1'b0; core_mem_available = 1'b1;
    tick(); tick();
    chk("clken_hold", 32'(core_mem_enable), 32'd1);
    clk_en = 1'b1;
    tick();
    chk("clken_release", 32'(core_mem_enable), 32'd0);

    // Async reset while a beat is held on the bus.
    core_mem_available = 1'b0;
    exp_beat(15'h0030, 2'b01, MODE_WRITE, DT_SBYTE, 16'h7777, 4'd0);
    send(2'd1, 16'h0060, 1'b0, 1'b0, 16'h0077, 4'd0);
    chk("issue_enable", 32'(core_mem_enable), 32'd1);
    #2 async_rst = 1'b1;
    #1;
    chk("arst_enable", 32'(core_mem_enable), 32'd0);
    chk("arst_busy", 32'(lsu_busy), 32'd0);
    beat_q.delete();
    wb_q.delete();
    tick(); tick();
    async_rst = 1'b0; core_mem_available = 1'b1;
    #1 chk("arst_idle_ready", 32'(req_ready), 32'd1);
    exp_beat(15'h0044, 2'b11, MODE_WRITE, DT_HALF, 16'hCAFE, 4'd0);
    send(2'd1, 16'h0088, 1'b1, 1'b0, 16'hCAFE, 4'd0);
    tick(); tick();

    chk("misalign_count", 32'(mis_cnt), 32'd2);
    chk("beat_q_empty", 32'(beat_q.size()), 32'd0);
    chk("wb_q_empty", 32'(wb_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
